// File: rtl/rv_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package rv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // One decoded-side entry: the fetch address and the word returned for it.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_pkt_t;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used both as the in-flight PC queue and
// as the response buffer. Flush and reset dominate push/pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when an entry leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer/count update and storage write.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches,
// buffers in-order responses and hands {pc, instr} to decode. Redirects flush
// everything and drop the responses still owed by memory.
module if_fetch_stage
    import rv_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [CNT_W-1:0] inflight, inflight_next, drop_cnt;

    logic            req_fire, rsp_take, credit_ok;
    logic [XLEN-1:0] pcq_dout;
    logic [CNT_W-1:0] pcq_count, buf_count;
    logic            pcq_full, pcq_empty, buf_full, buf_empty;
    fetch_pkt_t      buf_din, buf_dout;
    logic            unused_sigs;

    // Credit covers both outstanding fetches and buffered words, so a response
    // always finds a free slot and memory never needs backpressure.
    assign credit_ok      = ({1'b0, inflight} + {1'b0, buf_count}) < (CNT_W + 1)'(BUF_DEPTH);
    assign imem_req_valid = !reset && (state == FETCH) && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses only land in the buffer in normal operation; the one racing a
    // redirect belongs to the discarded stream.
    assign rsp_take       = imem_rsp_valid && (state == FETCH) && !redirect_valid;

    // Every response retires one outstanding fetch, whichever state consumes it.
    assign inflight_next  = inflight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    assign buf_din.pc     = pcq_dout;
    assign buf_din.instr  = imem_rsp_data;

    assign out_valid      = !reset && !buf_empty;
    assign out_pc         = buf_dout.pc;
    assign out_instr      = buf_dout.instr;

    assign unused_sigs    = ^{pcq_count, pcq_full, pcq_empty, buf_full};

    // PC, outstanding-fetch count and the FETCH/DRAIN state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            state    <= FETCH;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_valid) begin
                pc       <= align_pc(redirect_pc);
                drop_cnt <= inflight_next;
                state    <= (inflight_next != '0) ? DRAIN : FETCH;
            end else begin
                if (req_fire)
                    pc <= pc + XLEN'(PC_STEP);
                if (state == DRAIN && imem_rsp_valid) begin
                    drop_cnt <= drop_cnt - 1'b1;
                    if (drop_cnt == CNT_W'(1))
                        state <= FETCH;
                end
            end
        end
    end

    // Addresses of accepted fetches, matched to responses in order.
    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(XLEN)) u_pcq (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .din   (pc),
        .pop   (rsp_take),
        .dout  (pcq_dout),
        .flush (redirect_valid),
        .count (pcq_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    // Completed {pc, instr} pairs waiting for decode.
    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH($bits(fetch_pkt_t))) u_rspbuf (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_take),
        .din   (buf_din),
        .pop   (out_valid && out_ready),
        .dout  (buf_dout),
        .flush (redirect_valid),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a 1-cycle in-order memory model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    logic        rsp_en;
    logic [31:0] q[$];
    int          acc_cnt = 0;
    int          checks  = 0;
    int          errors  = 0;

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h100), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory: records accepted fetches, answers the oldest one a cycle later when enabled.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            imem_rsp_valid <= 1'b0;
            acc_cnt        <= 0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                q.push_back(imem_req_addr);
                acc_cnt <= acc_cnt + 1;
            end
            if (rsp_en && q.size() > 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= memf(q[0]);
                void'(q.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
        #1;
    endtask

    // Wait (bounded) for the next delivered instruction and check it; out_ready must be 1.
    task automatic expect_out(input logic [31:0] epc, input int maxw);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxw && !seen; i++) begin
            if (out_valid === 1'b1) begin
                chk("out_pc", out_pc, epc);
                chk("out_instr", out_instr, memf(epc));
                seen = 1'b1;
            end
            nc();
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL out_timeout observed=none expected_pc=%h", epc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        rsp_en         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        nc();
        nc();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);

        // 1: first fetch address and stability under stall
        reset = 1'b0;
        #1;
        chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_req_addr", imem_req_addr, 32'h100);
        chk("t1_out_valid", {31'b0, out_valid}, 32'd0);
        nc();
        chk("t1_stall_addr", imem_req_addr, 32'h100);

        // 2: streaming with 1-cycle memory
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        rsp_en         = 1'b1;
        #1;
        chk("t2_a0_addr", imem_req_addr, 32'h100);
        nc();
        chk("t2_a1_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t2_a1_addr", imem_req_addr, 32'h104);
        nc();
        chk("t2_a2_out_pc", out_pc, 32'h100);
        chk("t2_a2_credit", {31'b0, imem_req_valid}, 32'd0);
        nc();
        chk("t2_a3_out_pc", out_pc, 32'h104);
        chk("t2_a3_addr", imem_req_addr, 32'h108);
        nc();
        chk("t2_a4_out_valid", {31'b0, out_valid}, 32'd0);
        expect_out(32'h108, 4);
        expect_out(32'h10C, 4);

        // reset mid-stream
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        nc();
        reset     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("postrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("postrst_req_addr", imem_req_addr, 32'h100);

        // 3: decode stalled, credit exhausted, nothing lost
        repeat (6) nc();
        chk("t3_acc_cnt", acc_cnt, 32'd2);
        chk("t3_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("t3_out_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        #1;
        expect_out(32'h100, 2);
        expect_out(32'h104, 3);
        expect_out(32'h108, 6);

        // 4: redirect with two fetches in flight, memory held off
        reset  = 1'b1;
        rsp_en = 1'b0;
        nc();
        reset = 1'b0;
        #1;
        chk("t4_c0_addr", imem_req_addr, 32'h100);
        nc();
        chk("t4_c1_addr", imem_req_addr, 32'h104);
        nc();
        chk("t4_c2_credit", {31'b0, imem_req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2003;
        #1;
        nc();
        redirect_valid = 1'b0;
        rsp_en         = 1'b1;
        #1;
        chk("t4_drain_no_req", {31'b0, imem_req_valid}, 32'd0);
        chk("t4_drain_out", {31'b0, out_valid}, 32'd0);
        expect_out(32'h2000, 10);
        expect_out(32'h2004, 6);

        // 5: redirect coinciding with a response
        for (int i = 0; i < 8 && imem_rsp_valid !== 1'b1; i++) nc();
        chk("t5_rsp_seen", {31'b0, imem_rsp_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        #1;
        chk("t5_req_suppressed", {31'b0, imem_req_valid}, 32'd0);
        nc();
        redirect_valid = 1'b0;
        #1;
        chk("t5_flushed", {31'b0, out_valid}, 32'd0);
        expect_out(32'h3000, 10);
        expect_out(32'h3004, 6);

        // 6: PC wrap at the top of the address space
        imem_req_ready = 1'b0;
        repeat (6) nc();
        chk("t6_idle", {31'b0, out_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        nc();
        redirect_valid = 1'b0;
        #1;
        chk("t6_pre_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t6_pre_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        nc();
        chk("t6_wrap_addr", imem_req_addr, 32'h0);
        expect_out(32'hFFFF_FFFC, 4);
        expect_out(32'h0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
